// File: rtl/pcm_mem_player.sv
// pcm_mem_player
//   Plays a block of PCM samples out of the shared sample memory. On a NIOS
//   start command it reads WORDS words from address 0 upward and shifts each
//   one MSB-first onto a three-wire serial link (bit clock, frame sync, data).
//   Consecutive words follow each other with no idle bits. The next word is
//   always being fetched while the current one shifts out.
//
// Ports
//   clk, reset                 system clock, asynchronous active-low reset
//   pcm_ply_ctl_export  [3:0]  command: 0x3 start, 0x4 acknowledge, 0x8 abort
//   pcm_ply_rsp_export  [3:0]  status : 0x0 idle, 0x2 busy, 0x4 done, 0x8 error
//   pcm_mem_mm_*               read-only Avalon-MM master side of the memory
//                              (readdata valid READ_LAT cycles after address)
//   pcm_sclk / pcm_fs / pcm_sdata
//                              serial bit clock, frame sync (MSB of each word)
//                              and data; data changes on the sclk falling edge
module pcm_mem_player #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 2048,
    parameter int CLK_DIV  = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        pcm_ply_ctl_export,
    output logic [3:0]        pcm_ply_rsp_export,
    output logic [ADDR_W-1:0] pcm_mem_mm_address,
    output logic              pcm_mem_mm_chipselect,
    output logic              pcm_mem_mm_clken,
    output logic              pcm_mem_mm_write,
    input  logic [DATA_W-1:0] pcm_mem_mm_readdata,
    output logic [DATA_W-1:0] pcm_mem_mm_writedata,
    output logic [1:0]        pcm_mem_mm_byteenable,
    output logic              pcm_sclk,
    output logic              pcm_fs,
    output logic              pcm_sdata
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LAT_W = 3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_TAKE  = LAT_W'(1);

    localparam logic [3:0] CTL_START = 4'h3;
    localparam logic [3:0] CTL_ACK   = 4'h4;
    localparam logic [3:0] CTL_ABORT = 4'h8;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_PLAY, S_DONE, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              bit_end;
    logic              word_end;
    logic              run_end;
    logic              abort_req;
    logic [ADDR_W-1:0] addr_next;
    logic              play_out;

    assign bit_end   = (div_q == DIV_LAST);
    assign word_end  = bit_end && (bit_q == BIT_LAST);
    assign run_end   = word_end && (word_q == LAST_ADDR);
    assign abort_req = (pcm_ply_ctl_export == CTL_ABORT);
    // Address saturates on the last word so it never wraps within a run.
    assign addr_next = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            lat_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            lat_q   <= lat_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
        end
    end

    // Abort wins over both the end of priming and the end of the run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pcm_ply_ctl_export == CTL_START) state_d = S_PRIME;
            S_PRIME: begin
                if (abort_req)               state_d = S_ERROR;
                else if (lat_q == LAT_LAST)  state_d = S_PLAY;
            end
            S_PLAY: begin
                if (abort_req)    state_d = S_ERROR;
                else if (run_end) state_d = S_DONE;
            end
            S_DONE, S_ERROR: if (pcm_ply_ctl_export == CTL_ACK) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // lat_q counts the priming wait in PRIME; in PLAY it is a countdown that
    // reaches 1 exactly when the prefetched word is valid on readdata.
    always_comb begin
        addr_d  = addr_q;
        word_d  = word_q;
        div_d   = div_q;
        bit_d   = bit_q;
        lat_d   = lat_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        case (state_q)
            S_PRIME: begin
                if (state_d == S_PLAY) begin
                    shift_d = pcm_mem_mm_readdata;
                    addr_d  = addr_next;
                    lat_d   = LAT_LOAD;
                end else if (state_d == S_PRIME) begin
                    lat_d = lat_q + 1'b1;
                end else begin
                    lat_d = '0;
                end
            end
            S_PLAY: begin
                if (state_d == S_PLAY) begin
                    div_d = bit_end ? '0 : div_q + 1'b1;
                    if (lat_q != '0)      lat_d  = lat_q - 1'b1;
                    if (lat_q == LAT_TAKE) hold_d = pcm_mem_mm_readdata;
                    if (word_end) begin
                        shift_d = hold_q;
                        bit_d   = '0;
                        word_d  = word_q + 1'b1;
                        addr_d  = addr_next;
                        lat_d   = LAT_LOAD;
                    end else if (bit_end) begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    // Leaving the run: counters clear, address is held for NIOS.
                    div_d   = '0;
                    bit_d   = '0;
                    word_d  = '0;
                    lat_d   = '0;
                    shift_d = '0;
                    hold_d  = '0;
                end
            end
            S_DONE, S_ERROR: if (state_d == S_IDLE) addr_d = '0;
            default: ;
        endcase
    end

    // Serial lines are gated by the abort command itself so they drop in the
    // abort cycle, before the state register reaches ERROR.
    always_comb begin
        play_out  = (state_q == S_PLAY) && !abort_req;
        pcm_sclk  = play_out && (div_q >= DIV_HALF);
        pcm_fs    = play_out && (bit_q == '0);
        pcm_sdata = play_out && shift_q[DATA_W-1];
        case (state_q)
            S_PRIME, S_PLAY: pcm_ply_rsp_export = 4'h2;
            S_DONE:          pcm_ply_rsp_export = 4'h4;
            S_ERROR:         pcm_ply_rsp_export = 4'h8;
            default:         pcm_ply_rsp_export = 4'h0;
        endcase
    end

    assign pcm_mem_mm_address    = addr_q;
    assign pcm_mem_mm_chipselect = 1'b1;
    assign pcm_mem_mm_clken      = 1'b1;
    assign pcm_mem_mm_write      = 1'b0;
    assign pcm_mem_mm_writedata  = '0;
    assign pcm_mem_mm_byteenable = 2'b11;

endmodule
